// File: rtl/fft_sdf_stage_pkg.sv
// Shared complex-word field layout and SDF stage state encodings.
package fft_sdf_stage_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAIR  = 2'd1,
    PUSH  = 2'd2,
    DRAIN = 2'd3
  } sdf_state_t;

  localparam int IMGN_LSB = 0;

  function automatic int cplx_width(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int real_msb(input int data_w);
    return 2 * data_w - 1;
  endfunction

  function automatic int real_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int imgn_msb(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// DEPTH-entry delay line: shared read/write address, combinational read, no reset.
module sdf_delay_line #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_dat_i,
  output logic [WIDTH-1:0]  rd_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[addr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[addr_i];

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 SDF stage: registered output 1 clk after accept; in_ready drops only while draining.
// FFT_SDF_SCALE_EN: butterfly computed at DATA_W+1 bits then halved (floor).
module fft_sdf_stage
  import fft_sdf_stage_pkg::*;
#(
  parameter int DELAY  = 8,
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [cplx_width(DATA_W)-1:0] in_data,
  input  logic                          flush,
  output logic                          out_valid,
  output logic                          out_first,
  output logic [cplx_width(DATA_W)-1:0] out_data
);

  localparam int CPLX_W = cplx_width(DATA_W);
  localparam int RE_MSB = real_msb(DATA_W);
  localparam int RE_LSB = real_lsb(DATA_W);
  localparam int IM_MSB = imgn_msb(DATA_W);
  localparam int CNT_W  = $clog2(DELAY);

  sdf_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_first_q, out_first_d;
  logic [CPLX_W-1:0] out_data_q, out_data_d;

  logic              accept, advance, cnt_last, cnt_zero;
  logic              wr_en;
  logic [CPLX_W-1:0] wr_dat, rd_dat, bf_sum, bf_dif;

  function automatic logic [DATA_W-1:0] bfly(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              sub);
`ifdef FFT_SDF_SCALE_EN
    logic signed [DATA_W:0] w;
    w = sub ? ($signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b}))
            : ($signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b}));
    return DATA_W'(w >>> 1);
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  assign in_ready = (state_q != DRAIN);
  assign accept   = in_valid && (state_q != DRAIN);
  assign advance  = accept || (state_q == DRAIN);
  assign cnt_last = (cnt_q == CNT_W'(DELAY - 1));
  assign cnt_zero = (cnt_q == '0);

  assign bf_sum = {bfly(rd_dat[RE_MSB:RE_LSB], in_data[RE_MSB:RE_LSB], 1'b0),
                   bfly(rd_dat[IM_MSB:IMGN_LSB], in_data[IM_MSB:IMGN_LSB], 1'b0)};
  assign bf_dif = {bfly(rd_dat[RE_MSB:RE_LSB], in_data[RE_MSB:RE_LSB], 1'b1),
                   bfly(rd_dat[IM_MSB:IMGN_LSB], in_data[IM_MSB:IMGN_LSB], 1'b1)};

  sdf_delay_line #(
    .DEPTH (DELAY),
    .WIDTH (CPLX_W)
  ) u_delay_line (
    .clk_i    (clk),
    .addr_i   (cnt_q),
    .wr_en_i  (wr_en),
    .wr_dat_i (wr_dat),
    .rd_dat_o (rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_data_q  <= out_data_d;
    end
  end

  // Drain may only start at a block boundary, and a valid input always wins over flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = advance ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      FILL:  if (accept && cnt_last) state_d = PAIR;
      PAIR:  if (accept && cnt_last) state_d = PUSH;
      PUSH: begin
        if (accept && cnt_last)                 state_d = PAIR;
        else if (!in_valid && flush && cnt_zero) state_d = DRAIN;
      end
      DRAIN: if (cnt_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_data_d  = out_data_q;
    wr_en       = 1'b0;
    wr_dat      = in_data;
    case (state_q)
      FILL: wr_en = accept;
      PAIR: begin
        wr_en  = accept;
        wr_dat = bf_dif;
        if (accept) begin
          out_valid_d = 1'b1;
          out_first_d = cnt_zero;
          out_data_d  = bf_sum;
        end
      end
      PUSH: begin
        wr_en = accept;
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_dat;
        end
      end
      DRAIN: begin
        wr_en       = 1'b1;
        wr_dat      = '0;
        out_valid_d = 1'b1;
        out_data_d  = rd_dat;
      end
      default: ;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage (DELAY=4) with a block-level scoreboard model.
module tb_fft_sdf_stage;

  localparam int D  = 4;
  localparam int DW = 16;
  localparam int CW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_first;
  logic [CW-1:0] out_data;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          first;
    logic [CW-1:0] dat;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [CW-1:0] fh[D];
  logic [CW-1:0] pend[D];
  logic [CW-1:0] npend[D];
  int            sidx = 0;
  bit            pend_v = 1'b0;

  fft_sdf_stage #(.DELAY(D), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] comp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input bit sub);
    int s;
    s = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
`ifdef FFT_SDF_SCALE_EN
    s = s >>> 1;
`endif
    return s[DW-1:0];
  endfunction

  function automatic logic [CW-1:0] cx(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                       input bit sub);
    return {comp(a[CW-1:DW], b[CW-1:DW], sub), comp(a[DW-1:0], b[DW-1:0], sub)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Block model: first half buffered (and releases the previous block's differences),
  // second half yields sums now and differences for the next block.
  task automatic model(input logic [CW-1:0] d);
    int k;
    if (sidx < D) begin
      fh[sidx] = d;
      if (pend_v) exp_q.push_back('{first: 1'b0, dat: pend[sidx]});
    end else begin
      k = sidx - D;
      exp_q.push_back('{first: (k == 0), dat: cx(fh[k], d, 1'b0)});
      npend[k] = cx(fh[k], d, 1'b1);
    end
    sidx++;
    if (sidx == 2 * D) begin
      sidx   = 0;
      pend   = npend;
      pend_v = 1'b1;
    end
  endtask

  task automatic put(input logic [CW-1:0] d, input bit fl);
    model(d);
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_flush();
    flush    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_mid_block_ignored", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    for (int k = 0; k < D; k++)
      if (pend_v) exp_q.push_back('{first: 1'b0, dat: pend[k]});
    pend_v   = 1'b0;
    sidx     = 0;
    flush    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    while (in_ready !== 1'b1 && n < 3 * D) begin
      n++;
      @(negedge clk);
    end
    chk("drain_ready_low_cycles", 32'(n), 32'(D));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_first"}, 32'(out_first), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      total++;
      assert (exp_q.size() != 0)
      else begin
        bad++;
        $error("FAIL unexpected_output observed=%h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        total++;
        assert (out_data === mon_e.dat)
        else begin
          bad++;
          $error("FAIL out_data observed=%h expected=%h", out_data, mon_e.dat);
        end
        total++;
        assert (out_first === mon_e.first)
        else begin
          bad++;
          $error("FAIL out_first observed=%b expected=%b", out_first, mon_e.first);
        end
      end
    end
  end

  initial begin
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Impulse block, then drain
    put({16'd1, 16'd0}, 1'b0);
    for (int i = 0; i < 7; i++) put('0, 1'b0);
    drain();

    // Real ramp 1..8
    for (int i = 1; i <= 8; i++) put({16'(i), 16'd0}, 1'b0);

    // Three random blocks with gaps; mid-block flush ignored; flush with valid at boundary
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 2 * D; i++) begin
        if (b == 1 && i == 2) idle_flush();
        idle($urandom_range(0, 2));
        put(CW'($urandom), (b == 2 && i == 0));
        if (b == 2 && i == 0) chk("flush_with_valid_no_drain", 32'(in_ready), 32'd1);
      end
    end
    drain();

    // Overflow corner
    for (int i = 0; i < 2 * D; i++) put(32'h7FFF_8000, 1'b0);
    drain();

    // Reset during PAIR
    for (int i = 0; i < 6; i++) put({16'(i + 3), 16'(i * 7)}, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    sidx   = 0;
    pend_v = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2 * D; i++) put({16'(10 * i), 16'(-i)}, 1'b0);
    drain();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
